div_top: RTL and testbench
==========================

# div_top

Iterative unsigned integer divider behind a Xilinx-divider-style interface (`divi_top`): 25-bit dividend, 16-bit divisor, 25-bit quotient, 16-bit fractional/remainder output, `rfd` ready-for-data flag, global clock enable `ce`. It is a drop-in replacement for the vendor divider core in datapaths clocked by `sys_clk`. It computes one quotient bit per enabled clock with a restoring shift-subtract algorithm.

## Interface
- No parameters; widths fixed.
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `ce`  in  1  clock enable; when 0, all internal state and outputs hold.
- `dividend`  in  25  unsigned dividend.
- `divisor`  in  16  unsigned divisor.
- `quotient`  out  25  registered unsigned quotient of the last completed division.
- `fractional`  out  16  registered remainder by default, or fractional quotient bits with `DIVI_FRACT_EN`.
- `rfd`  out  1  ready for data; 1 = idle, next enabled edge captures the operands.

## Operation
- Two-state FSM.
  - IDLE (`rfd`=1): on an edge with `ce`=1, latch `dividend` and `divisor` into internal registers, clear the partial remainder, load the iteration counter, go to BUSY.
  - BUSY (`rfd`=0): on each edge with `ce`=1, perform one restoring step.
    - Remainder is 17 bits: shift left and bring in the next dividend bit, MSB first.
    - If the remainder is ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - After the final step, register `quotient` and `fractional`, then return to IDLE.
- Operand changes during BUSY are ignored; only the latched copies are used.
- With `ce` held at 1 and constant operands, the block recomputes back-to-back. Outputs are refreshed with identical values every pass.
- Outputs hold the last result until the next completion; they never show partial results.
- Divide by zero (divisor=0 at capture):
  - `quotient`=25'h1FFFFFF.
  - `fractional`=16'hFFFF in both modes.
  - Latency is unchanged.
- Remainder is always < divisor and fits in 16 bits.
- Arithmetic is unsigned only.

## Timing
- Reset values: `quotient`=0, `fractional`=0, `rfd`=1, FSM=IDLE, counter=0.
- Reset asserted mid-division aborts the division immediately. After release the block is IDLE and outputs are 0.
- Latency: let E0 be the capture edge.
  - `rfd` is 0 after E0.
  - The 25 iteration edges are E1..E25.
  - On E25, `quotient` and `fractional` update and `rfd` returns to 1.
  - Throughput is one result per 26 enabled edges.
- With `DIVI_FRACT_EN` there are 41 iteration edges (E1..E41), giving a throughput of one result per 42 enabled edges.
- `ce`=0 edges do not count toward latency.
- Assertion of `ce` is sampled like any other synchronous input; the first capture can occur on the first edge where `ce`=1.

## Configuration
- `DIVI_FRACT_EN` undefined:
  - `fractional` = integer remainder (dividend mod divisor).
  - 25 iterations.
- `DIVI_FRACT_EN` defined:
  - After the 25 integer steps, run 16 further steps with zero shifted in as the dividend bit.
  - `fractional` = floor(remainder·2^16 / divisor), i.e. the binary fraction of the quotient, MSB = 2^-1.
  - `quotient` is unchanged.
  - 41 iterations.

## Test plan
- Reset with `ce`=0 for 100 ns, then `ce`=1, dividend=120, divisor=10 → `rfd` drops after the first enabled edge and rises 25 edges later; `quotient`=12, `fractional`=0. Values stay at 12/0 on repeated passes.
- Dividend=125, divisor=10:
  - Default → `quotient`=12, `fractional`=5.
  - `DIVI_FRACT_EN` → `quotient`=12, `fractional`=16'h8000, `rfd` high after 41 edges.
- Dividend=25'h1FFFFFF, divisor=16'hFFFF → `quotient`=512, `fractional`=511 (default).
- Divisor=0, dividend=7 → `quotient`=25'h1FFFFFF, `fractional`=16'hFFFF, normal latency.
- `ce` toggled low for 10 cycles mid-division, and dividend changed during BUSY → result equals that of the originally captured operands; latency is extended by exactly 10 cycles.
- `sys_rst_n` pulsed low during BUSY → immediately `quotient`=0, `fractional`=0, `rfd`=1; the next division completes correctly.

Source files
------------

// File: rtl/div_top.sv
// Iterative restoring unsigned divider, 25-bit dividend / 16-bit divisor, one quotient bit per enabled edge.
// Optional macro DIVI_FRACT_EN: 16 extra steps produce fractional quotient bits instead of the remainder.
// Latency: 1 capture + 25 steps (41 with DIVI_FRACT_EN); rfd=0 while busy, ce=0 stalls everything.
module div_top (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        ce,
    input  logic [24:0] dividend,
    input  logic [15:0] divisor,
    output logic [24:0] quotient,
    output logic [15:0] fractional,
    output logic        rfd
);

`ifdef DIVI_FRACT_EN
    localparam int QW = 41;
`else
    localparam int QW = 25;
`endif
    localparam logic [5:0] ITER   = 6'(QW);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic [5:0]    r_cnt;
    logic [24:0]   r_dvd;
    logic [15:0]   r_dvs;
    logic [15:0]   r_rem;
    logic [QW-2:0] r_q;
    logic          r_dz;
    logic [24:0]   r_quot;
    logic [15:0]   r_frac;

    logic [16:0]   w_rem_sh;
    logic          w_ge;
    logic [15:0]   w_rem_nx;
    logic [QW-1:0] w_q_nx;
    logic [24:0]   w_quo;
    logic [15:0]   w_fra;
    logic          w_last;

    // Dividend register shifts left with zero fill, so the fractional steps see zero bits for free.
    assign w_rem_sh = {r_rem, r_dvd[24]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nx = 16'(w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh);
    assign w_q_nx   = {r_q, w_ge};
    assign w_last   = (r_cnt == 6'd1);

`ifdef DIVI_FRACT_EN
    assign w_quo = w_q_nx[40:16];
    assign w_fra = w_q_nx[15:0];
`else
    assign w_quo = w_q_nx;
    assign w_fra = w_rem_nx;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_dz    <= 1'b0;
            r_quot  <= '0;
            r_frac  <= '0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    r_dvd   <= dividend;
                    r_dvs   <= divisor;
                    r_dz    <= (divisor == 16'd0);
                    r_rem   <= '0;
                    r_q     <= '0;
                    r_cnt   <= ITER;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_dvd <= {r_dvd[23:0], 1'b0};
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx[QW-2:0];
                    r_cnt <= r_cnt - 6'd1;
                    if (w_last) begin
                        // Divide-by-zero overrides whatever the datapath accumulated.
                        r_quot  <= r_dz ? 25'h1FFFFFF : w_quo;
                        r_frac  <= r_dz ? 16'hFFFF : w_fra;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign quotient   = r_quot;
    assign fractional = r_frac;
    assign rfd        = (r_state == S_IDLE);

endmodule

// File: tb/tb_div_top.sv
// Self-checking bench for div_top: table of divisions run back-to-back, plus ce-stall and reset-abort sequences.
module tb_div_top;

`ifdef DIVI_FRACT_EN
    localparam int ITER = 41;
`else
    localparam int ITER = 25;
`endif

    logic        sys_clk;
    logic        sys_rst_n;
    logic        ce;
    logic [24:0] dividend;
    logic [15:0] divisor;
    logic [24:0] quotient;
    logic [15:0] fractional;
    logic        rfd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [24:0] dvd;
        logic [15:0] dvs;
        logic [24:0] q;
        logic [15:0] r;
    } vec_t;

    typedef struct {
        logic [24:0] q;
        logic [15:0] f;
    } exp_t;

    vec_t        tbl [10];
    exp_t        sb [$];
    logic [24:0] last_q;
    logic [15:0] last_f;

    div_top dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .ce         (ce),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .fractional (fractional),
        .rfd        (rfd)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected fractional output from the integer remainder.
    function automatic logic [15:0] exp_frac(input logic [15:0] r, input logic [15:0] d);
`ifdef DIVI_FRACT_EN
        logic [31:0] t;
        if (d == 16'd0) return 16'hFFFF;
        t = {r, 16'h0000} / {16'h0000, d};
        return t[15:0];
`else
        return (d == 16'd0) ? 16'hFFFF : r;
`endif
    endfunction

    // Called at a negedge with the DUT idle: drive operands, let the capture edge pass.
    task automatic start(input logic [24:0] dvd, input logic [15:0] dvs,
                         input logic [24:0] eq, input logic [15:0] er, input bit push);
        exp_t e;
        dividend = dvd;
        divisor  = dvs;
        if (push) begin
            e.q = eq;
            e.f = exp_frac(er, dvs);
            sb.push_back(e);
        end
        @(negedge sys_clk);
        chk("rfd_drop", {31'd0, rfd}, 32'd0);
        chk("hold_q", {7'd0, quotient}, {7'd0, last_q});
        chk("hold_f", {16'd0, fractional}, {16'd0, last_f});
    endtask

    // Counts negedges until rfd rises; n0 is the number already elapsed since the capture edge.
    task automatic finish_div(input string nm, input int n0, input int exp_n);
        int   n;
        exp_t e;
        n = n0;
        while (!rfd && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        chk({nm, "_latency"}, n, exp_n);
        if (sb.size() == 0) begin
            chk({nm, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_q"}, {7'd0, quotient}, {7'd0, e.q});
            chk({nm, "_f"}, {16'd0, fractional}, {16'd0, e.f});
            last_q = e.q;
            last_f = e.f;
        end
    endtask

    initial begin
        tbl[0] = '{25'd120,       16'd10,     25'd12,        16'd0};
        tbl[1] = '{25'd120,       16'd10,     25'd12,        16'd0};
        tbl[2] = '{25'd125,       16'd10,     25'd12,        16'd5};
        tbl[3] = '{25'h1FFFFFF,   16'hFFFF,   25'd512,       16'd511};
        tbl[4] = '{25'd7,         16'd0,      25'h1FFFFFF,   16'hFFFF};
        tbl[5] = '{25'd5,         16'd7,      25'd0,         16'd5};
        tbl[6] = '{25'd1000000,   16'd1,      25'd1000000,   16'd0};
        tbl[7] = '{25'h1FFFFFF,   16'd2,      25'hFFFFFF,    16'd1};
        tbl[8] = '{25'd100,       16'd100,    25'd1,         16'd0};
        tbl[9] = '{25'd1234567,   16'd1000,   25'd1234,      16'd567};

        last_q    = '0;
        last_f    = '0;
        ce        = 1'b0;
        dividend  = '0;
        divisor   = '0;
        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        #100;
        chk("rst_q", {7'd0, quotient}, 32'd0);
        chk("rst_f", {16'd0, fractional}, 32'd0);
        chk("rst_rfd", {31'd0, rfd}, 32'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        dividend  = 25'd99;
        divisor   = 16'd3;
        repeat (3) @(negedge sys_clk);
        chk("ce0_rfd", {31'd0, rfd}, 32'd1);
        chk("ce0_q", {7'd0, quotient}, 32'd0);

        ce = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, 1'b1);
            finish_div($sformatf("vec%0d", i), 0, ITER);
        end

        // Stall 10 edges mid-division and change the dividend while busy.
        start(25'd125, 16'd10, 25'd12, 16'd5, 1'b1);
        repeat (5) @(negedge sys_clk);
        dividend = 25'd999;
        ce       = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("stall_rfd", {31'd0, rfd}, 32'd0);
        ce = 1'b1;
        finish_div("stall", 15, ITER + 10);

        // Reset mid-division aborts and clears the outputs.
        start(25'd500, 16'd7, 25'd0, 16'd0, 1'b0);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_q", {7'd0, quotient}, 32'd0);
        chk("abort_f", {16'd0, fractional}, 32'd0);
        chk("abort_rfd", {31'd0, rfd}, 32'd1);
        last_q = '0;
        last_f = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        start(25'd500, 16'd7, 25'd71, 16'd3, 1'b1);
        finish_div("post_rst", 0, ITER);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
